mem_stage: RTL

- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Consumes EX/MEM control and data, performs loads/stores on a single-outstanding req/ready data-memory bus, and formats load data.
- Produces the MEM/WB pipeline register outputs.
- Asserts mem_stall while a bus access is in flight; the hazard unit freezes PC, IF/ID, ID/EX and EX/MEM on mem_stall.

---
 rtl/mem_stage_pkg.sv | 86 ++++++++
 rtl/mem_stage_load_align.sv | 37 +++
 rtl/mem_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and helpers for the memory-access pipeline stage.
//   state_t      : bus-access FSM state (IDLE, BUSY, DONE)
//   F3_*         : funct3 encodings for access size / signedness
//   size_t       : decoded access size (byte, half, word)
//   held_t       : instruction fields latched while a bus access is in flight
//   access_size  : funct3 -> size; unknown encodings fall back to word
//   lane_enables : byte enables for a given size and byte lane
//   store_lanes  : store data replicated across all lanes of its size
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef struct packed {
    logic        memtoreg;
    logic        regwrite;
    logic        jal;
    logic        jalr;
    logic        is_load;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [31:0] alu_result;
    logic [31:0] link_address;
    logic [4:0]  reg_dest;
  } held_t;

  // Stores only have SB/SH/SW, so the unsigned encodings fall through to word.
  function automatic size_t access_size(input logic [2:0] funct3, input logic is_store);
    size_t size;
    size = SZ_WORD;
    if (is_store) begin
      case (funct3)
        F3_B:    size = SZ_BYTE;
        F3_H:    size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: size = SZ_BYTE;
        F3_H, F3_HU: size = SZ_HALF;
        default:     size = SZ_WORD;
      endcase
    end
    return size;
  endfunction

  function automatic logic [3:0] lane_enables(input size_t size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicating the datum means the memory picks the right lane purely from be.
  function automatic logic [31:0] store_lanes(input size_t size, input logic [31:0] data);
    logic [31:0] wdata;
    case (size)
      SZ_BYTE: wdata = {4{data[7:0]}};
      SZ_HALF: wdata = {2{data[15:0]}};
      default: wdata = data;
    endcase
    return wdata;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load formatter: picks the addressed byte/half out of a bus
// word and sign- or zero-extends it according to funct3.
//   rdata  in  32  raw word returned by the data memory
//   addr   in   2  byte lane of the access
//   funct3 in   3  LB/LH/LW/LBU/LHU (anything else behaves as LW)
//   result out 32  value written back to the register file
// -----------------------------------------------------------------------------
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{addr, 3'b000} +: 8];
  assign half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

  // NOTE: result gets a value on every path (default arm) so no latch is inferred.
  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   result = {24'h000000, byte_lane};
      F3_H:    result = {{16{half_lane[15]}}, half_lane};
      F3_HU:   result = {16'h0000, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage between EX/MEM and MEM/WB. Loads and stores go
// out over a single-outstanding req/ready bus; upstream is frozen with
// mem_stall while an access is in flight, and a stuck bus is aborted after
// BUS_TIMEOUT wait cycles with mem_wb_bus_err set.
//
// Build option: define MISALIGN_TRAP_EN to flag misaligned half/word accesses
// (no bus access, mem_wb_misalign=1, regwrite suppressed). Without it the low
// address bits beyond the access size are simply ignored.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   ex_mem_*                EX/MEM register contents (controls, address, data)
//   dmem_req/we/addr/wdata/be  registered bus request (addr word-aligned)
//   dmem_rdata, dmem_ready  bus response
//   mem_stall               freeze PC, IF/ID, ID/EX and EX/MEM
//   mem_wb_*                MEM/WB register outputs
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_mem_memread,
  input  logic        ex_mem_memwrite,
  input  logic        ex_mem_memtoreg,
  input  logic        ex_mem_regwrite,
  input  logic        ex_mem_jal,
  input  logic        ex_mem_jalr,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_data_read2,
  input  logic [4:0]  ex_mem_reg_dest,
  input  logic [31:0] ex_mem_link_address,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        mem_wb_regwrite,
  output logic        mem_wb_memtoreg,
  output logic        mem_wb_jal,
  output logic        mem_wb_jalr,
  output logic [31:0] mem_wb_read_data,
  output logic [31:0] mem_wb_alu_result,
  output logic [31:0] mem_wb_link_address,
  output logic [4:0]  mem_wb_reg_dest,
  output logic        mem_wb_bus_err,
  output logic        mem_wb_misalign
);

  localparam int CNT_W = (BUS_TIMEOUT < 1) ? 1 : $clog2(BUS_TIMEOUT + 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  timeout_cnt;
  held_t             held;
  logic [31:0]       rdata_q;
  logic              bus_err_q;
  logic [31:0]       load_result;

  logic  is_store, is_load, mem_op, misalign, start, timed_out;
  size_t size;

  // A store wins when both memread and memwrite are set.
  assign is_store  = ex_mem_memwrite;
  assign is_load   = ex_mem_memread & ~ex_mem_memwrite;
  assign mem_op    = ex_mem_memread | ex_mem_memwrite;
  assign size      = access_size(ex_mem_funct3, is_store);
  assign timed_out = (timeout_cnt == CNT_W'(BUS_TIMEOUT));

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (mem_op) begin
      case (size)
        SZ_HALF: misalign = ex_mem_alu_result[0];
        SZ_WORD: misalign = |ex_mem_alu_result[1:0];
        default: misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  // A trapped access never touches the bus; it flows through like an ALU op.
  assign start = (state == IDLE) && mem_op && !misalign;

  always_comb begin
    state_next = state;
    mem_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = BUSY;
          mem_stall  = 1'b1;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (dmem_ready || timed_out) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // The hazard unit must not see a stall while the core is held in reset.
    if (!reset_n) mem_stall = 1'b0;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Bus request, timeout counter and the instruction held across the access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_be     <= '0;
      timeout_cnt <= '0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      held        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dmem_req          <= 1'b1;
            dmem_we           <= is_store;
            dmem_addr         <= {ex_mem_alu_result[31:2], 2'b00};
            dmem_be           <= lane_enables(size, ex_mem_alu_result[1:0]);
            dmem_wdata        <= is_store ? store_lanes(size, ex_mem_data_read2) : '0;
            timeout_cnt       <= '0;
            rdata_q           <= '0;
            bus_err_q         <= 1'b0;
            held.memtoreg     <= ex_mem_memtoreg;
            held.regwrite     <= ex_mem_regwrite;
            held.jal          <= ex_mem_jal;
            held.jalr         <= ex_mem_jalr;
            held.is_load      <= is_load;
            held.funct3       <= ex_mem_funct3;
            held.lane         <= ex_mem_alu_result[1:0];
            held.alu_result   <= ex_mem_alu_result;
            held.link_address <= ex_mem_link_address;
            held.reg_dest     <= ex_mem_reg_dest;
          end
        end
        BUSY: begin
          // ready is checked first so a response on the timeout cycle still succeeds.
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            rdata_q  <= held.is_load ? dmem_rdata : '0;
          end else if (timed_out) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            bus_err_q <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  load_align u_load_align (
    .rdata  (rdata_q),
    .addr   (held.lane),
    .funct3 (held.funct3),
    .result (load_result)
  );

  // MEM/WB register: loads straight from EX/MEM for non-memory (or trapped)
  // instructions, from the held copy when an access completes, else holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_wb_regwrite     <= 1'b0;
      mem_wb_memtoreg     <= 1'b0;
      mem_wb_jal          <= 1'b0;
      mem_wb_jalr         <= 1'b0;
      mem_wb_read_data    <= '0;
      mem_wb_alu_result   <= '0;
      mem_wb_link_address <= '0;
      mem_wb_reg_dest     <= '0;
      mem_wb_bus_err      <= 1'b0;
    end else if (state == IDLE && !start) begin
      mem_wb_regwrite     <= ex_mem_regwrite & ~misalign;
      mem_wb_memtoreg     <= ex_mem_memtoreg;
      mem_wb_jal          <= ex_mem_jal;
      mem_wb_jalr         <= ex_mem_jalr;
      mem_wb_read_data    <= '0;
      mem_wb_alu_result   <= ex_mem_alu_result;
      mem_wb_link_address <= ex_mem_link_address;
      mem_wb_reg_dest     <= ex_mem_reg_dest;
      mem_wb_bus_err      <= 1'b0;
    end else if (state == DONE) begin
      mem_wb_regwrite     <= held.regwrite & ~bus_err_q;
      mem_wb_memtoreg     <= held.memtoreg;
      mem_wb_jal          <= held.jal;
      mem_wb_jalr         <= held.jalr;
      mem_wb_read_data    <= (held.is_load && !bus_err_q) ? load_result : '0;
      mem_wb_alu_result   <= held.alu_result;
      mem_wb_link_address <= held.link_address;
      mem_wb_reg_dest     <= held.reg_dest;
      mem_wb_bus_err      <= bus_err_q;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      misalign_q <= 1'b0;
    else if (state == IDLE && !start)  misalign_q <= misalign;
    else if (state == DONE)            misalign_q <= 1'b0;
  end

  assign mem_wb_misalign = misalign_q;
`else
  assign mem_wb_misalign = 1'b0;
`endif

endmodule
